mips_multicycle_core: RTL
=========================

Name: mips_multicycle_core

Overview:
- Parametrised multicycle MIPS-subset core. Successor to the single-cycle top-level CPU.
- Instructions execute over several states of one control FSM, sharing one ALU.
- Instruction memory: external, combinational read.
- Data memory: external, with a req/ack handshake that allows wait states.
- Includes an internal 32-entry register file, a debug read port, and an instruction-boundary step enable.

Parameters:
- DATA_W, 32: datapath and register width (≥16).
- PC_W, 5: word-addressed PC width; instruction memory depth = 2^PC_W.
- DADDR_W, 5: data memory word-address width; taken from ALU result bits [DADDR_W-1:0].

Ports:
- clk  in  1: clock, rising edge.
- rst  in  1: synchronous, active-low reset.
- en  in  1: step enable, sampled only in FETCH.
- imem_addr  out  PC_W: instruction address, equal to pc.
- imem_data  in  32: instruction word; combinational from imem_addr.
- dmem_req  out  1: data access request.
- dmem_we  out  1: 1 = write, 0 = read; valid while dmem_req is high.
- dmem_addr  out  DADDR_W: data word address.
- dmem_wdata  out  DATA_W: store data (rt).
- dmem_rdata  in  DATA_W: load data; valid when dmem_ack is high.
- dmem_ack  in  1: access complete, one-cycle pulse.
- dbg_addr  in  5: debug register select.
- dbg_data  out  DATA_W: combinational read of reg[dbg_addr].
- pc  out  PC_W: current PC.
- instr_done  out  1: one-cycle pulse when an instruction retires.
- illegal  out  1: one-cycle pulse when an unsupported opcode/funct is seen.

Behaviour:
- Reset (rst==0 at posedge): pc=0, IR=0, all 32 registers=0, state=FETCH, dmem_req=0, instr_done=0, illegal=0.
- Register $0 reads 0 always; writes to it are discarded.
- Supported instructions:
  - R-type (op 0x00): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed).
  - I-type: addi 0x08, lw 0x23, sw 0x2B, beq 0x04.
  - J-type: j 0x02.
- Immediates are sign-extended 16→DATA_W.
- Arithmetic is modulo 2^DATA_W; overflow is ignored (no trap).
- FSM states and transitions:
  - FETCH: if en, IR<=imem_data, pc<=pc+1 (wraps mod 2^PC_W), go to DECODE; else hold.
  - DECODE: A<=reg[rs], B<=reg[rt]. Branch on op: R→EXEC_R, addi→EXEC_I, lw/sw→MEM_ADDR, beq→BRANCH, j→JUMP, other→FETCH with illegal pulse (no state change, pc already advanced).
  - EXEC_R: ALUOut<=A op B; unsupported funct→FETCH with illegal pulse; else→WB_R.
  - EXEC_I: ALUOut<=A+simm→WB_I.
  - WB_R: reg[rd]<=ALUOut, instr_done, →FETCH.
  - WB_I: reg[rt]<=ALUOut, instr_done, →FETCH.
  - MEM_ADDR: ALUOut<=A+simm; lw→MEM_RD, sw→MEM_WR.
  - MEM_RD: dmem_req=1, dmem_we=0. Stay until dmem_ack; then MDR<=dmem_rdata, →MEM_WB.
  - MEM_WB: reg[rt]<=MDR, instr_done, →FETCH.
  - MEM_WR: dmem_req=1, dmem_we=1, dmem_wdata=B. Stay until dmem_ack; then instr_done, →FETCH.
  - BRANCH: if A==B, pc<=pc+simm[PC_W-1:0] (pc already = PC+1; wraps). instr_done, →FETCH.
  - JUMP: pc<=IR[PC_W-1:0], instr_done, →FETCH.
- Cycle counts with zero wait: R/addi 4, lw 5, sw 4, beq 3, j 3. Each cycle dmem_ack is late adds one cycle.
- Handshake rules:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are registered and held stable until the ack cycle.
  - dmem_req drops the cycle after ack.
  - dmem_ack outside MEM_RD/MEM_WR is ignored.
  - dmem_ack in the first request cycle is legal.
- en low only stalls at an instruction boundary. An instruction already in flight completes.
- Reset mid-instruction or mid-handshake aborts immediately: dmem_req=0 on the next edge, no register write.
- dbg_data reflects a write on the cycle after the write edge.

Optional Feature:
- MIPS_MULT_EN defined: R-type funct 0x18 is legal. EXEC_R computes the low DATA_W bits of the signed A*B; WB_R writes it to rd; 4 cycles total.
- MIPS_MULT_EN undefined: funct 0x18 is illegal, as in EXEC_R above (illegal pulse, no write, →FETCH).

Test Plan:
- Reset then program "addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2" with en=1 → dbg $3 = 2; instr_done pulses at cycles 4, 8, 12; pc=3.
- "sw $1,4($0)" with $1=0x55, ack after 3 wait cycles → dmem_req high 4 cycles, dmem_we=1, dmem_addr=4, dmem_wdata=0x55; instruction takes 7 cycles.
- "lw $5,4($0)" with dmem_rdata=0xDEADBEEF, ack immediate → $5 = 0xDEADBEEF after 5 cycles; ack asserted during FETCH has no effect.
- beq taken at pc=2 with imm=-3 → pc=0; beq not taken → pc=3. "j 31" at pc=31 → pc=31; next fetch at pc=31 wraps pc to 0.
- en=0 held for 10 cycles at FETCH → pc and registers unchanged; pulling rst low during MEM_RD → dmem_req=0, pc=0, registers=0 next cycle.
- Opcode 0x3F → illegal pulse, pc+1, no register change. Funct 0x18 with $1=7, $2=-6 → $3=-42 if MIPS_MULT_EN, else illegal pulse and $3 unchanged.

Source files
------------

// File: rtl/mips_multicycle_core_if.sv
// rtl/mips_multicycle_core_if.sv - data memory req/ack bus between the core (master) and memory (slave)
interface mips_multicycle_core_if #(
    parameter int DATA_W  = 32,
    parameter int DADDR_W = 5
);
    logic               req;
    logic               we;
    logic [DADDR_W-1:0] addr;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  rdata;
    logic               ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multicycle MIPS-subset core with one shared ALU and a req/ack data port
// Defining MIPS_MULT_EN makes R-type funct 0x18 a signed multiply (low DATA_W bits).
module mips_multicycle_core #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 5,
    parameter int DADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [PC_W-1:0]       imem_addr,
    input  logic [31:0]           imem_data,
    mips_multicycle_core_if.master dmem,
    input  logic [4:0]            dbg_addr,
    output logic [DATA_W-1:0]     dbg_data,
    output logic [PC_W-1:0]       pc,
    output logic                  instr_done,
    output logic                  illegal
);
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_MULT = 6'h18;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I,
        S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP
    } state_t;

    state_t              state_q;
    logic [PC_W-1:0]     pc_q;
    logic [31:0]         ir_q;
    logic [DATA_W-1:0]   a_q, b_q, alu_q, mdr_q;
    logic [DATA_W-1:0]   regs_q [32];
    logic                dmem_req_q, dmem_we_q;
    logic [DADDR_W-1:0]  dmem_addr_q;
    logic [DATA_W-1:0]   dmem_wdata_q;
    logic                instr_done_q, illegal_q;

    logic [5:0]          op, funct;
    logic [4:0]          rs, rt, rd;
    logic [DATA_W-1:0]   simm, addr_sum, r_res;
    logic                r_ok;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign simm     = DATA_W'($signed(ir_q[15:0]));
    assign addr_sum = a_q + simm;

    always_comb begin
        r_res = '0;
        r_ok  = 1'b1;
        case (funct)
            F_ADD:   r_res = a_q + b_q;
            F_SUB:   r_res = a_q - b_q;
            F_AND:   r_res = a_q & b_q;
            F_OR:    r_res = a_q | b_q;
            F_SLT:   r_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
`ifdef MIPS_MULT_EN
            F_MULT:  r_res = DATA_W'($signed(a_q) * $signed(b_q));
`else
            F_MULT:  r_ok  = 1'b0;
`endif
            default: r_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_FETCH;
            pc_q         <= '0;
            ir_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            alu_q        <= '0;
            mdr_q        <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            instr_done_q <= 1'b0;
            illegal_q    <= 1'b0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            instr_done_q <= 1'b0;
            illegal_q    <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (en) begin
                        ir_q    <= imem_data;
                        pc_q    <= pc_q + PC_W'(1);
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q <= regs_q[rs];
                    b_q <= regs_q[rt];
                    case (op)
                        OP_R:         state_q <= S_EXEC_R;
                        OP_ADDI:      state_q <= S_EXEC_I;
                        OP_LW, OP_SW: state_q <= S_MEM_ADDR;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_J:         state_q <= S_JUMP;
                        default: begin
                            illegal_q <= 1'b1;
                            state_q   <= S_FETCH;
                        end
                    endcase
                end
                S_EXEC_R: begin
                    alu_q <= r_res;
                    if (r_ok) begin
                        state_q <= S_WB_R;
                    end else begin
                        illegal_q <= 1'b1;
                        state_q   <= S_FETCH;
                    end
                end
                S_EXEC_I: begin
                    alu_q   <= addr_sum;
                    state_q <= S_WB_I;
                end
                S_WB_R: begin
                    if (rd != 5'd0) regs_q[rd] <= alu_q;
                    instr_done_q <= 1'b1;
                    state_q      <= S_FETCH;
                end
                S_WB_I: begin
                    if (rt != 5'd0) regs_q[rt] <= alu_q;
                    instr_done_q <= 1'b1;
                    state_q      <= S_FETCH;
                end
                // Bus outputs are launched here so they are already stable in the first request cycle.
                S_MEM_ADDR: begin
                    alu_q        <= addr_sum;
                    dmem_addr_q  <= addr_sum[DADDR_W-1:0];
                    dmem_wdata_q <= b_q;
                    dmem_req_q   <= 1'b1;
                    dmem_we_q    <= (op == OP_SW);
                    state_q      <= (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    if (dmem.ack) begin
                        mdr_q      <= dmem.rdata;
                        dmem_req_q <= 1'b0;
                        state_q    <= S_MEM_WB;
                    end
                end
                S_MEM_WB: begin
                    if (rt != 5'd0) regs_q[rt] <= mdr_q;
                    instr_done_q <= 1'b1;
                    state_q      <= S_FETCH;
                end
                S_MEM_WR: begin
                    if (dmem.ack) begin
                        dmem_req_q   <= 1'b0;
                        instr_done_q <= 1'b1;
                        state_q      <= S_FETCH;
                    end
                end
                S_BRANCH: begin
                    if (a_q == b_q) pc_q <= pc_q + simm[PC_W-1:0];
                    instr_done_q <= 1'b1;
                    state_q      <= S_FETCH;
                end
                S_JUMP: begin
                    pc_q         <= ir_q[PC_W-1:0];
                    instr_done_q <= 1'b1;
                    state_q      <= S_FETCH;
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign dbg_data   = regs_q[dbg_addr];
    assign instr_done = instr_done_q;
    assign illegal    = illegal_q;
    assign dmem.req   = dmem_req_q;
    assign dmem.we    = dmem_we_q;
    assign dmem.addr  = dmem_addr_q;
    assign dmem.wdata = dmem_wdata_q;
endmodule
